ak4619_cfg_seq: RTL and testbench

AK4619_CFG_SEQ -- requirements
Module: ak4619_cfg_seq

---
 rtl/ak4619_cfg_seq.sv | 223 ++++++++++++++++++++++
 tb/tb_ak4619_cfg_seq.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ak4619_cfg_seq.sv
// AK4619 codec bring-up sequencer: holds pdn for a tick count, waits, then replays a
// (register, value) table over a byte-level I2C master; afterwards accepts single runtime writes.
//
// state    | meaning
// PDN_HOLD | pdn low, counting tick pulses
// WAKE     | pdn high, counting tick pulses before the first transaction
// FETCH    | waiting on the table read, then latching {reg, value}
// START    | presenting START
// ADDR     | presenting WRITE {DEV_ADDR, 0}
// REG      | presenting WRITE register address
// DATA     | presenting WRITE value
// STOP     | presenting STOP
// WAIT_RSP | one command accepted, waiting for its response
// READY    | init complete, runtime write port open
// FAULT    | init transaction exhausted its retries; parked until rst

module ak4619_cfg_seq #(
    parameter logic [6:0] DEV_ADDR   = 7'h10,
    parameter int         N_REGS     = 21,
    parameter int         PDN_TICKS  = 20000,
    parameter int         WAKE_TICKS = 16,
    parameter int         RETRIES    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    output logic        pdn,
    output logic [5:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [1:0]  cmd_kind,
    output logic [7:0]  cmd_data,
    input  logic        rsp_valid,
    input  logic        rsp_nack,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [7:0]  wr_reg,
    input  logic [7:0]  wr_data,
    output logic        cfg_done,
    output logic        busy,
    output logic        error
);

    localparam int CNT_MAX = (PDN_TICKS > WAKE_TICKS) ? PDN_TICKS : WAKE_TICKS;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int RW      = $clog2(RETRIES + 2);

    localparam logic [CW-1:0] PDN_LAST   = CW'(PDN_TICKS - 1);
    localparam logic [CW-1:0] WAKE_LAST  = CW'(WAKE_TICKS - 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(RETRIES);
    localparam logic [5:0]    LAST_ENTRY = 6'(N_REGS - 1);

    localparam logic [3:0] S_PDN_HOLD = 4'd0;
    localparam logic [3:0] S_WAKE     = 4'd1;
    localparam logic [3:0] S_FETCH    = 4'd2;
    localparam logic [3:0] S_START    = 4'd3;
    localparam logic [3:0] S_ADDR     = 4'd4;
    localparam logic [3:0] S_REG      = 4'd5;
    localparam logic [3:0] S_DATA     = 4'd6;
    localparam logic [3:0] S_STOP     = 4'd7;
    localparam logic [3:0] S_WAIT_RSP = 4'd8;
    localparam logic [3:0] S_READY    = 4'd9;
    localparam logic [3:0] S_FAULT    = 4'd10;

    logic [3:0]    state_q, state_d;
    logic [3:0]    pend_q, pend_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          nack_q, nack_d;
    logic          fetch_wait_q, fetch_wait_d;
    logic [5:0]    rom_addr_q, rom_addr_d;
    logic [7:0]    reg_q, reg_d;
    logic [7:0]    val_q, val_d;
    logic          cfg_done_q, cfg_done_d;
    logic          error_q, error_d;

    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        cnt_d        = cnt_q;
        retry_d      = retry_q;
        nack_d       = nack_q;
        fetch_wait_d = fetch_wait_q;
        rom_addr_d   = rom_addr_q;
        reg_d        = reg_q;
        val_d        = val_q;
        cfg_done_d   = cfg_done_q;
        error_d      = error_q;
        case (state_q)
            S_PDN_HOLD: if (tick) begin
                if (cnt_q == PDN_LAST) begin
                    cnt_d   = '0;
                    state_d = S_WAKE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAKE: if (tick) begin
                if (cnt_q == WAKE_LAST) begin
                    cnt_d        = '0;
                    rom_addr_d   = '0;
                    fetch_wait_d = 1'b1;
                    state_d      = S_FETCH;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_FETCH: begin
                // first cycle lets the table read settle after rom_addr moved
                if (fetch_wait_q) begin
                    fetch_wait_d = 1'b0;
                end else begin
                    reg_d   = rom_data[15:8];
                    val_d   = rom_data[7:0];
                    retry_d = '0;
                    nack_d  = 1'b0;
                    state_d = S_START;
                end
            end
            S_START, S_ADDR, S_REG, S_DATA, S_STOP: if (cmd_ready) begin
                pend_d  = state_q;
                state_d = S_WAIT_RSP;
            end
            S_WAIT_RSP: if (rsp_valid) begin
                case (pend_q)
                    S_START: state_d = S_ADDR;
                    S_ADDR:  state_d = rsp_nack ? S_STOP : S_REG;
                    S_REG:   state_d = rsp_nack ? S_STOP : S_DATA;
                    S_DATA:  state_d = S_STOP;
                    S_STOP: begin
                        if (nack_q) begin
                            nack_d = 1'b0;
                            if (retry_q == RETRY_LAST) begin
                                error_d = 1'b1;
                                retry_d = '0;
                                state_d = cfg_done_q ? S_READY : S_FAULT;
                            end else begin
                                retry_d = retry_q + RW'(1);
                                state_d = S_START;
                            end
                        end else begin
                            retry_d = '0;
                            if (cfg_done_q) begin
                                state_d = S_READY;
                            end else if (rom_addr_q == LAST_ENTRY) begin
                                cfg_done_d = 1'b1;
                                state_d    = S_READY;
                            end else begin
                                rom_addr_d   = rom_addr_q + 6'd1;
                                fetch_wait_d = 1'b1;
                                state_d      = S_FETCH;
                            end
                        end
                    end
                    default: state_d = S_PDN_HOLD;
                endcase
                if (rsp_nack && (pend_q == S_ADDR || pend_q == S_REG || pend_q == S_DATA)) begin
                    nack_d = 1'b1;
                end
            end
            S_READY: if (wr_valid) begin
                reg_d   = wr_reg;
                val_d   = wr_data;
                retry_d = '0;
                nack_d  = 1'b0;
                state_d = S_START;
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_PDN_HOLD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_PDN_HOLD;
            pend_q       <= S_PDN_HOLD;
            cnt_q        <= '0;
            retry_q      <= '0;
            nack_q       <= 1'b0;
            fetch_wait_q <= 1'b0;
            rom_addr_q   <= '0;
            reg_q        <= '0;
            val_q        <= '0;
            cfg_done_q   <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            nack_q       <= nack_d;
            fetch_wait_q <= fetch_wait_d;
            rom_addr_q   <= rom_addr_d;
            reg_q        <= reg_d;
            val_q        <= val_d;
            cfg_done_q   <= cfg_done_d;
            error_q      <= error_d;
        end
    end

    always_comb begin
        cmd_kind = 2'd0;
        cmd_data = 8'h00;
        case (state_q)
            S_ADDR: begin cmd_kind = 2'd1; cmd_data = {DEV_ADDR, 1'b0}; end
            S_REG:  begin cmd_kind = 2'd1; cmd_data = reg_q; end
            S_DATA: begin cmd_kind = 2'd1; cmd_data = val_q; end
            S_STOP: cmd_kind = 2'd2;
            default: ;
        endcase
    end

    assign cmd_valid = (state_q == S_START) || (state_q == S_ADDR) || (state_q == S_REG) ||
                       (state_q == S_DATA) || (state_q == S_STOP);
    assign pdn       = (state_q != S_PDN_HOLD);
    assign rom_addr  = rom_addr_q;
    assign wr_ready  = (state_q == S_READY);
    assign busy      = (state_q != S_READY) && (state_q != S_FAULT);
    assign cfg_done  = cfg_done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_ak4619_cfg_seq.sv
// Randomized bench for ak4619_cfg_seq: an I2C-master responder with injectable NACKs and
// stalls, and a reference model that expands the config table into the expected command list.
module tb_ak4619_cfg_seq;

    localparam int         RETRIES = 3;
    localparam int         N_REGS  = 2;
    localparam logic [7:0] ADDR_W  = 8'h20;

    logic        clk = 1'b0;
    logic        rst, tick, cmd_ready, rsp_valid, rsp_nack, wr_valid;
    logic [15:0] rom_data;
    logic [7:0]  wr_reg, wr_data;
    logic        pdn, cmd_valid, wr_ready, cfg_done, busy, error;
    logic [5:0]  rom_addr;
    logic [1:0]  cmd_kind;
    logic [7:0]  cmd_data;

    ak4619_cfg_seq #(
        .DEV_ADDR(7'h10), .N_REGS(N_REGS), .PDN_TICKS(4), .WAKE_TICKS(2), .RETRIES(RETRIES)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .pdn(pdn), .rom_addr(rom_addr), .rom_data(rom_data),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_nack(rsp_nack), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_reg(wr_reg), .wr_data(wr_data), .cfg_done(cfg_done), .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    bit          ready_en, ready_rand, nack_addr_all;
    bit          nack_idx [64];
    int          w_cnt;
    logic [15:0] rom_tab [N_REGS];
    logic [9:0]  obs [$];
    logic [9:0]  exp_q [$];
    int          m_w;
    bit          exp_done, exp_err;

    function automatic bit nack_hit(input int w, input logic [7:0] d);
        return (w < 64 && nack_idx[w]) || (nack_addr_all && d == ADDR_W);
    endfunction

    // I2C master + synchronous table: acts on the falling edge, one response per accepted command
    initial begin
        logic [5:0] addr_seen;
        bit         rsp_pend, rsp_pend_nack;
        addr_seen = '0; rsp_pend = 0; rsp_pend_nack = 0;
        cmd_ready = 0; rsp_valid = 0; rsp_nack = 0; rom_data = '0;
        forever begin
            @(negedge clk);
            rsp_valid = 0;
            rsp_nack  = 0;
            rom_data  = rom_tab[addr_seen[0]];
            addr_seen = rom_addr;
            if (rsp_pend) begin
                rsp_valid = 1;
                rsp_nack  = rsp_pend_nack;
                rsp_pend  = 0;
            end
            cmd_ready = ready_en && (!ready_rand || $urandom_range(0, 2) != 0);
            if (cmd_valid && cmd_ready && !rst) begin
                obs.push_back({cmd_kind, cmd_data});
                rsp_pend      = 1;
                rsp_pend_nack = 0;
                if (cmd_kind == 2'd1) begin
                    rsp_pend_nack = nack_hit(w_cnt, cmd_data);
                    w_cnt++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // one register write as the I2C traffic it should produce, including retries
    task automatic model_txn(input logic [7:0] r, input logic [7:0] v, output bit ok);
        logic [7:0] bytes [3];
        bit         nk;
        bytes[0] = ADDR_W; bytes[1] = r; bytes[2] = v;
        ok = 0;
        for (int a = 0; a <= RETRIES && !ok; a++) begin
            nk = 0;
            exp_q.push_back({2'd0, 8'h00});
            for (int b = 0; b < 3 && !nk; b++) begin
                exp_q.push_back({2'd1, bytes[b]});
                nk = nack_hit(m_w, bytes[b]);
                m_w++;
            end
            exp_q.push_back({2'd2, 8'h00});
            ok = !nk;
        end
    endtask

    task automatic model_init();
        bit ok;
        m_w = 0; exp_q.delete(); exp_err = 0; exp_done = 1;
        for (int e = 0; e < N_REGS; e++) begin
            model_txn(rom_tab[e][15:8], rom_tab[e][7:0], ok);
            if (!ok) begin
                exp_err = 1; exp_done = 0;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1; tick = 0; wr_valid = 0;
        step(); step();
        rst = 0;
        obs.delete();
        w_cnt = 0;
    endtask

    task automatic clear_nacks();
        foreach (nack_idx[i]) nack_idx[i] = 0;
        nack_addr_all = 0;
    endtask

    task automatic bring_up(input string tag);
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 3)) step();
            checks++;
            if (pdn !== 1'b0) begin errors++; $display("FAIL %s_pdn_low before tick %0d got %b exp 0", tag, i + 1, pdn); end
            tick = 1; step(); tick = 0;
        end
        checks++;
        if (pdn !== 1'b1) begin errors++; $display("FAIL %s_pdn_rise got %b exp 1", tag, pdn); end
        for (int i = 0; i < 2; i++) begin
            repeat ($urandom_range(0, 3)) step();
            tick = 1; step(); tick = 0;
        end
    endtask

    // runs until busy drops; optionally pokes tick and wr_valid, which must both be ignored
    task automatic wait_idle(input bit poke, output bit timeout, output bit wr_seen);
        timeout = 1; wr_seen = 0;
        for (int i = 0; i < 3000; i++) begin
            if (poke) begin
                tick = 1'($urandom_range(0, 1));
                wr_valid = 1; wr_reg = 8'h06; wr_data = 8'h31;
            end
            step();
            if (busy && wr_ready) wr_seen = 1;
            if (!busy) begin timeout = 0; break; end
        end
        tick = 0; wr_valid = 0;
    endtask

    task automatic test_reset();
        rst = 1; tick = 0; wr_valid = 0;
        step(); step();
        checks++;
        if ({pdn, cmd_valid, cmd_kind, cmd_data, rom_addr, cfg_done, busy, error, wr_ready} !==
            {1'b0, 1'b0, 2'd0, 8'h00, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs got pdn=%b cv=%b k=%0d d=%h ra=%0d done=%b busy=%b err=%b wrr=%b exp 0 0 0 00 0 0 1 0 0",
                     pdn, cmd_valid, cmd_kind, cmd_data, rom_addr, cfg_done, busy, error, wr_ready);
        end
        rst = 0;
    endtask

    task automatic test_basic();
        bit to, wrs;
        rom_tab[0] = 16'h0036; rom_tab[1] = 16'h01AE;
        clear_nacks(); ready_en = 1; ready_rand = 0;
        do_reset();
        bring_up("basic");
        wait_idle(1, to, wrs);
        model_init();
        checks++; if (to)  begin errors++; $display("FAIL basic_timeout got busy=%b exp 0", busy); end
        checks++; if (wrs) begin errors++; $display("FAIL basic_wr_ready_during_init got 1 exp 0"); end
        checks++;
        if (obs.size() != exp_q.size()) begin errors++; $display("FAIL basic_len got %0d exp %0d", obs.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs.size()) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL basic_cmd[%0d] got %h exp %h", i, obs[i], exp_q[i]); end
        end
        checks++;
        if ({cfg_done, error, wr_ready} !== 3'b101) begin
            errors++; $display("FAIL basic_final got done=%b err=%b wrr=%b exp 1 0 1", cfg_done, error, wr_ready);
        end
        repeat (6) step();
        checks++;
        if (obs.size() != exp_q.size() || busy !== 1'b0) begin
            errors++; $display("FAIL basic_no_queue got cmds=%0d busy=%b exp %0d 0", obs.size(), busy, exp_q.size());
        end
    endtask

    task automatic test_runtime_write();
        bit to, wrs, ok;
        logic [7:0] r, v;
        obs.delete(); w_cnt = 0;
        wr_valid = 1; wr_reg = 8'h06; wr_data = 8'h31;
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rt_wr_ready got %b exp 1", wr_ready); end
        step();
        wr_valid = 0;
        checks++;
        if ({busy, wr_ready} !== 2'b10) begin errors++; $display("FAIL rt_accept got busy=%b wrr=%b exp 1 0", busy, wr_ready); end
        wait_idle(0, to, wrs);
        m_w = 0; exp_q.delete(); model_txn(8'h06, 8'h31, ok);
        checks++;
        if (obs.size() != exp_q.size()) begin errors++; $display("FAIL rt_len got %0d exp %0d", obs.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs.size()) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL rt_cmd[%0d] got %h exp %h", i, obs[i], exp_q[i]); end
        end
        checks++;
        if ({to, cfg_done, error, busy} !== 4'b0100) begin
            errors++; $display("FAIL rt_final got to=%b done=%b err=%b busy=%b exp 0 1 0 0", to, cfg_done, error, busy);
        end
        // runtime write whose address byte is never acknowledged
        nack_addr_all = 1; obs.delete(); w_cnt = 0;
        r = 8'($urandom); v = 8'($urandom);
        wr_valid = 1; wr_reg = r; wr_data = v;
        step();
        wr_valid = 0;
        wait_idle(0, to, wrs);
        m_w = 0; exp_q.delete(); model_txn(r, v, ok);
        checks++;
        if (obs.size() != exp_q.size()) begin errors++; $display("FAIL rtfail_len got %0d exp %0d", obs.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs.size()) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL rtfail_cmd[%0d] got %h exp %h", i, obs[i], exp_q[i]); end
        end
        checks++;
        if ({to, cfg_done, error, busy, wr_ready} !== {1'b0, 1'b1, !ok, 1'b0, 1'b1}) begin
            errors++; $display("FAIL rtfail_final got to=%b done=%b err=%b busy=%b wrr=%b exp 0 1 1 0 1", to, cfg_done, error, busy, wr_ready);
        end
        nack_addr_all = 0;
    endtask

    task automatic test_nack_reg();
        bit to, wrs;
        clear_nacks();
        nack_idx[1] = 1;
        do_reset();
        bring_up("nackreg");
        wait_idle(0, to, wrs);
        model_init();
        checks++;
        if (obs.size() != exp_q.size()) begin errors++; $display("FAIL nackreg_len got %0d exp %0d", obs.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs.size()) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL nackreg_cmd[%0d] got %h exp %h", i, obs[i], exp_q[i]); end
        end
        checks++;
        if ({to, cfg_done, error} !== 3'b010) begin
            errors++; $display("FAIL nackreg_final got to=%b done=%b err=%b exp 0 1 0", to, cfg_done, error);
        end
        clear_nacks();
    endtask

    task automatic test_fault();
        bit to, wrs;
        int n;
        clear_nacks();
        nack_addr_all = 1;
        do_reset();
        bring_up("fault");
        wait_idle(0, to, wrs);
        model_init();
        checks++;
        if (obs.size() != exp_q.size()) begin errors++; $display("FAIL fault_len got %0d exp %0d", obs.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs.size()) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL fault_cmd[%0d] got %h exp %h", i, obs[i], exp_q[i]); end
        end
        checks++;
        if ({to, error, cfg_done, busy, pdn, wr_ready} !== 6'b010010) begin
            errors++; $display("FAIL fault_final got to=%b err=%b done=%b busy=%b pdn=%b wrr=%b exp 0 1 0 0 1 0",
                               to, error, cfg_done, busy, pdn, wr_ready);
        end
        n = obs.size();
        for (int i = 0; i < 20; i++) begin
            tick = 1'($urandom_range(0, 1)); wr_valid = 1;
            step();
        end
        tick = 0; wr_valid = 0;
        checks++;
        if (obs.size() != n || cmd_valid !== 1'b0 || error !== 1'b1) begin
            errors++; $display("FAIL fault_parked got cmds=%0d cv=%b err=%b exp %0d 0 1", obs.size(), cmd_valid, error, n);
        end
        clear_nacks();
    endtask

    task automatic test_stall();
        bit to, wrs, seen, moved;
        logic [1:0] k;
        logic [7:0] d;
        clear_nacks();
        do_reset();
        bring_up("stall");
        for (int i = 0; i < 200 && obs.size() < 3; i++) step();
        ready_en = 0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            seen = cmd_valid;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL stall_present got cv=0 exp 1"); end
        k = cmd_kind; d = cmd_data; moved = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (cmd_valid !== 1'b1 || cmd_kind !== k || cmd_data !== d) moved = 1;
        end
        checks++;
        if (moved) begin errors++; $display("FAIL stall_hold got cv=%b k=%0d d=%h exp 1 %0d %h", cmd_valid, cmd_kind, cmd_data, k, d); end
        ready_en = 1;
        wait_idle(0, to, wrs);
        model_init();
        checks++;
        if (obs.size() != exp_q.size()) begin errors++; $display("FAIL stall_len got %0d exp %0d", obs.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs.size()) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL stall_cmd[%0d] got %h exp %h", i, obs[i], exp_q[i]); end
        end
        checks++;
        if ({to, cfg_done, error} !== 3'b010) begin errors++; $display("FAIL stall_final got to=%b done=%b err=%b exp 0 1 0", to, cfg_done, error); end
    endtask

    task automatic test_rst_mid();
        bit to, wrs, seen;
        clear_nacks();
        do_reset();
        bring_up("rstmid");
        for (int i = 0; i < 400 && obs.size() < 8; i++) step();
        ready_en = 0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            seen = cmd_valid && cmd_kind == 2'd1 && cmd_data == rom_tab[1][7:0];
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL rstmid_data_byte got k=%0d d=%h exp 1 %h", cmd_kind, cmd_data, rom_tab[1][7:0]); end
        rst = 1;
        step();
        checks++;
        if ({pdn, cmd_valid, rom_addr, busy, cfg_done} !== {1'b0, 1'b0, 6'd0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL rstmid_after got pdn=%b cv=%b ra=%0d busy=%b done=%b exp 0 0 0 1 0", pdn, cmd_valid, rom_addr, busy, cfg_done);
        end
        rst = 0;
        obs.delete(); w_cnt = 0; ready_en = 1;
        bring_up("rstmid_replay");
        wait_idle(0, to, wrs);
        model_init();
        checks++;
        if (obs.size() != exp_q.size()) begin errors++; $display("FAIL rstmid_len got %0d exp %0d", obs.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs.size()) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_cmd[%0d] got %h exp %h", i, obs[i], exp_q[i]); end
        end
        checks++;
        if ({to, cfg_done, error} !== 3'b010) begin errors++; $display("FAIL rstmid_final got to=%b done=%b err=%b exp 0 1 0", to, cfg_done, error); end
    endtask

    task automatic test_random();
        bit to, wrs;
        for (int it = 0; it < 5; it++) begin
            clear_nacks();
            foreach (rom_tab[e]) rom_tab[e] = 16'($urandom);
            foreach (nack_idx[i]) nack_idx[i] = ($urandom_range(0, 3) == 0);
            ready_rand = 1;
            do_reset();
            bring_up("rand");
            wait_idle(1, to, wrs);
            model_init();
            checks++;
            if (obs.size() != exp_q.size()) begin errors++; $display("FAIL rand%0d_len got %0d exp %0d", it, obs.size(), exp_q.size()); end
            foreach (exp_q[i]) if (i < obs.size()) begin
                checks++;
                if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_cmd[%0d] got %h exp %h", it, i, obs[i], exp_q[i]); end
            end
            checks++;
            if ({to, wrs, cfg_done, error, busy} !== {1'b0, 1'b0, exp_done, exp_err, 1'b0}) begin
                errors++; $display("FAIL rand%0d_final got to=%b wrr=%b done=%b err=%b busy=%b exp 0 0 %b %b 0",
                                   it, to, wrs, cfg_done, error, busy, exp_done, exp_err);
            end
        end
        ready_rand = 0;
        clear_nacks();
    endtask

    initial begin
        rst = 1; tick = 0; wr_valid = 0; wr_reg = '0; wr_data = '0;
        ready_en = 1; ready_rand = 0; w_cnt = 0; m_w = 0;
        clear_nacks();
        rom_tab[0] = 16'h0036; rom_tab[1] = 16'h01AE;
        test_reset();
        test_basic();
        test_runtime_write();
        test_nack_reg();
        test_fault();
        test_stall();
        test_rst_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
